hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Pipeline hazard and stall sequencer for the 5-stage RV32 core.
- Sits beside the ID stage.
- Detects load-use hazards and taken branches/jumps resolved in EX, and freezes the whole pipeline while data memory is busy.
- Drives PC/IF_ID write enables, IF_ID flush, and Ctrl_0_Sig to the ID-stage control mux (1 = pass controls, 0 = insert all-zero bubble).
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 255, max consecutive busy cycles in FREEZE before err_timeout sets (>=1)
TO_W, 8, width of the timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ID_rs1  in  5  rs1 address of instruction in ID
ID_rs2  in  5  rs2 address of instruction in ID
ID_use_rs1  in  1  ID instruction reads rs1
ID_use_rs2  in  1  ID instruction reads rs2
EX_MemRead  in  1  instruction in EX is a load
EX_rd  in  5  destination of EX instruction
EX_redirect  in  1  taken branch/JAL/JALR resolved in EX this cycle
dmem_req  in  1  MEM stage has an access outstanding
dmem_ready  in  1  data memory completes the access this cycle
PC_Write  out  1  PC register update enable
IF_ID_Write  out  1  IF/ID register update enable
IF_ID_Flush  out  1  clear IF/ID to NOP
Ctrl_0_Sig  out  1  1 = pass ID controls, 0 = bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
err_timeout  out  1  sticky: FREEZE exceeded MEM_TIMEOUT
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirect flushes, saturating

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, timeout counter=0, err_timeout=0, stall_cnt=0, flush_cnt=0.
- While rst=1, outputs are forced: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, Ctrl_0_Sig=0, pipe_freeze=0.
- Hazard terms (combinational):
  - load_use = EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
  - mem_busy = dmem_req & ~dmem_ready.
- FSM states: RUN, FREEZE.
  - RUN -> FREEZE when mem_busy.
  - FREEZE -> RUN when dmem_ready.
  - Otherwise the state holds.
- Output priority in RUN: mem_busy > EX_redirect > load_use > normal.
  - mem_busy (same cycle, Mealy): PC_Write=0, IF_ID_Write=0, pipe_freeze=1, IF_ID_Flush=0, Ctrl_0_Sig=1.
  - EX_redirect: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, Ctrl_0_Sig=0. A simultaneous load_use is discarded, because the younger instruction is squashed. flush_cnt increments.
  - load_use: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, Ctrl_0_Sig=0. Exactly one bubble per hazard. stall_cnt increments.
  - Normal: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, Ctrl_0_Sig=1, pipe_freeze=0.
- FREEZE:
  - While dmem_ready=0, outputs equal the mem_busy case. EX_redirect and load_use are ignored, and no counter changes.
  - In the cycle dmem_ready=1, pipe_freeze=0 and the RUN priority rules (excluding mem_busy) apply to the current inputs. A redirect or load-use held during the freeze is therefore acted on exactly once, at release.
- Timeout:
  - Counter increments each FREEZE cycle with dmem_ready=0.
  - Counter clears on entering RUN.
  - When it reaches MEM_TIMEOUT, err_timeout sets and stays set until rst. The FSM remains in FREEZE; there is no forced release.
- Counters saturate at 2^CNT_W-1 with no wrap.
- EX_rd=0 never causes a stall, even with EX_MemRead=1.

Decomposition:
- Shared package/header: FSM state encodings (ST_RUN, ST_FREEZE) and the Ctrl_0_Sig polarity constants (CTRL_PASS=1, CTRL_BUBBLE=0), added next to INVALID_VECTOR in RV32_Constants.vh.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice for stall_cnt and flush_cnt.
- Hazard compare logic and the FSM stay inline.

Test Plan:
- Load-use rs1: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 for one cycle -> PC_Write=0, IF_ID_Write=0, Ctrl_0_Sig=0 that cycle; stall_cnt 0->1; next cycle with EX_MemRead=0 -> all pass.
- x0 and unused source: EX_rd=0 matching ID_rs2, then EX_rd=7 with ID_rs2=7 and ID_use_rs2=0 -> no stall in either case; stall_cnt stays 0.
- Redirect plus load_use in the same cycle -> IF_ID_Flush=1, Ctrl_0_Sig=0, PC_Write=1; flush_cnt=1, stall_cnt=0.
- Freeze: dmem_req=1, dmem_ready=0 for 3 cycles with EX_redirect=1 -> pipe_freeze=1 and PC_Write=0 for 3 cycles with no counter change; on the 4th cycle dmem_ready=1 -> pipe_freeze=0, IF_ID_Flush=1, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_busy held for 6 cycles -> err_timeout rises after 4 busy FREEZE cycles; it stays 1 after release and clears only on rst.
- Reset mid-FREEZE: assert rst for 1 cycle -> state RUN, counters 0, err_timeout 0; during rst IF_ID_Flush=1, Ctrl_0_Sig=0, PC_Write=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the hazard/stall sequencer: FSM states and the
// polarity of the ID-stage control-mux select.
package hazard_ctrl_unit_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_FREEZE = 1'b1
   } state_e;

   localparam logic CTRL_PASS   = 1'b1;
   localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}}))
         count_d = count_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard and stall sequencer for the 5-stage RV32 core: load-use
// bubbles, EX-resolved redirect flushes and data-memory freezes.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_RUN    | pipeline flowing; load-use / redirect handled per cycle
// ST_FREEZE | waiting on data memory; whole pipeline held until ready
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rd,
   input  logic             EX_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             Ctrl_0_Sig,
   output logic             pipe_freeze,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            err_q, err_d;
   logic            load_use, mem_busy, hold;
   logic            stall_inc, flush_inc;

   assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                     ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                      (ID_use_rs2 && (ID_rs2 == EX_rd)));
   assign mem_busy = dmem_req && !dmem_ready;

   // In FREEZE only dmem_ready releases; in RUN an outstanding miss holds.
   assign hold = (state_q == ST_FREEZE) ? !dmem_ready : mem_busy;

   always_comb begin
      state_d     = state_q;
      to_d        = to_q;
      err_d       = err_q;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      Ctrl_0_Sig  = CTRL_PASS;
      pipe_freeze = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      case (state_q)
         ST_RUN: if (mem_busy) state_d = ST_FREEZE;
         ST_FREEZE: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
               to_d    = '0;
            end else begin
               if (to_q != TO_W'(MEM_TIMEOUT)) to_d = to_q + TO_W'(1);
               if (to_q == TO_W'(MEM_TIMEOUT - 1)) err_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (hold) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         pipe_freeze = 1'b1;
      end else if (EX_redirect) begin
         IF_ID_Flush = 1'b1;
         Ctrl_0_Sig  = CTRL_BUBBLE;
         flush_inc   = 1'b1;
      end else if (load_use) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         Ctrl_0_Sig  = CTRL_BUBBLE;
         stall_inc   = 1'b1;
      end

      if (rst) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         Ctrl_0_Sig  = CTRL_BUBBLE;
         pipe_freeze = 1'b0;
         stall_inc   = 1'b0;
         flush_inc   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         to_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end

   assign err_timeout = err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_hazard_ctrl_unit;

   localparam int CNT_W = 4;

   // {PC_Write, IF_ID_Write, IF_ID_Flush, Ctrl_0_Sig, pipe_freeze}
   localparam logic [4:0] O_N = 5'b11010;
   localparam logic [4:0] O_S = 5'b00000;
   localparam logic [4:0] O_R = 5'b11100;
   localparam logic [4:0] O_F = 5'b00011;
   localparam logic [4:0] O_X = 5'b00100;

   typedef struct {
      logic [4:0]       outs;
      logic             err;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
   logic ID_use_rs1 = 0, ID_use_rs2 = 0, EX_MemRead = 0, EX_redirect = 0;
   logic dmem_req = 0, dmem_ready = 0;
   logic PC_Write, IF_ID_Write, IF_ID_Flush, Ctrl_0_Sig, pipe_freeze, err_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .ID_rs1      (ID_rs1),
      .ID_rs2      (ID_rs2),
      .ID_use_rs1  (ID_use_rs1),
      .ID_use_rs2  (ID_use_rs2),
      .EX_MemRead  (EX_MemRead),
      .EX_rd       (EX_rd),
      .EX_redirect (EX_redirect),
      .dmem_req    (dmem_req),
      .dmem_ready  (dmem_ready),
      .PC_Write    (PC_Write),
      .IF_ID_Write (IF_ID_Write),
      .IF_ID_Flush (IF_ID_Flush),
      .Ctrl_0_Sig  (Ctrl_0_Sig),
      .pipe_freeze (pipe_freeze),
      .err_timeout (err_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // Counts in an expectation are the values visible before this cycle's edge.
   task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                       input logic redir, input logic req, input logic rdy,
                       input logic [4:0] eo, input logic ee, input int esc, input int efc,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ID_rs1 = rs1; ID_rs2 = rs2; ID_use_rs1 = u1; ID_use_rs2 = u2;
      EX_MemRead = mr; EX_rd = rd; EX_redirect = redir; dmem_req = req; dmem_ready = rdy;
      e.outs = eo; e.err = ee; e.sc = CNT_W'(esc); e.fc = CNT_W'(efc); e.name = nm;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [4:0] act;
         e = exp_q.pop_front();
         act = {PC_Write, IF_ID_Write, IF_ID_Flush, Ctrl_0_Sig, pipe_freeze};
         checks = checks + 4;
         if (act !== e.outs) begin
            errors = errors + 1;
            $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.outs);
         end
         if (err_timeout !== e.err) begin
            errors = errors + 1;
            $display("FAIL %s err_timeout: got %b expected %b", e.name, err_timeout, e.err);
         end
         if (stall_cnt !== e.sc) begin
            errors = errors + 1;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
         end
         if (flush_cnt !== e.fc) begin
            errors = errors + 1;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      //    rst rs1 rs2 u1 u2 mr rd redir req rdy  outs err sc fc
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_X, 0, 0, 0, "reset");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 0, 0, "idle");
      step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0,  O_S, 0, 0, 0, "lu_rs1");
      step(0, 5, 0, 1, 0, 0, 5, 0, 0, 0,  O_N, 0, 1, 0, "after_lu");
      step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  O_N, 0, 1, 0, "rd_x0");
      step(0, 0, 7, 0, 0, 1, 7, 0, 0, 0,  O_N, 0, 1, 0, "rs2_unused");
      step(0, 0, 7, 0, 1, 1, 7, 0, 0, 0,  O_S, 0, 1, 0, "lu_rs2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 2, 0, "idle2");
      step(0, 5, 0, 1, 0, 1, 5, 1, 0, 0,  O_R, 0, 2, 0, "redir_lu");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 2, 1, "idle3");
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  O_F, 0, 2, 1, "frz1");
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  O_F, 0, 2, 1, "frz2");
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  O_F, 0, 2, 1, "frz3");
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  O_R, 0, 2, 1, "frz_rel_redir");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 2, 2, "idle4");
      step(0, 3, 0, 1, 0, 1, 3, 0, 1, 0,  O_F, 0, 2, 2, "frz_lu1");
      step(0, 3, 0, 1, 0, 1, 3, 0, 1, 0,  O_F, 0, 2, 2, "frz_lu2");
      step(0, 3, 0, 1, 0, 1, 3, 0, 1, 1,  O_S, 0, 2, 2, "frz_rel_lu");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 3, 2, "idle5");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 3, 2, "to_run");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 3, 2, "to_f1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 3, 2, "to_f2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 3, 2, "to_f3");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 3, 2, "to_f4");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 1, 3, 2, "to_set");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  O_N, 1, 3, 2, "to_release");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 1, 3, 2, "to_sticky");
      for (int i = 0; i < 14; i++)
         step(0, 9, 0, 1, 0, 1, 9, 0, 0, 0, O_S, 1, (3 + i > 15) ? 15 : 3 + i, 2, "sat_stall");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 1, 15, 2, "sat_hold");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 1, 15, 2, "mid_run");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 1, 15, 2, "mid_frz");
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  O_X, 1, 15, 2, "mid_rst");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_N, 0, 0, 0, "post_rst");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  O_F, 0, 0, 0, "post_rst_busy");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  O_F, 0, 0, 0, "post_rst_frz");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  O_N, 0, 0, 0, "post_rst_rel");
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
